// File: rtl/rv_pipe_pkg.sv
// Shared pipeline types: fetch FSM states, the bubble instruction and the IF/ID record.
// Latency: none (types and pure functions only).
// Backpressure: none; consumers apply their own hold/flush controls.
package rv_pipe_pkg;

    // Fetch stage sequencing: one boot cycle, normal fetch, then a terminal fault state.
    typedef enum logic [1:0] {
        FETCH_BOOT = 2'd0,
        FETCH_RUN  = 2'd1,
        FETCH_HALT = 2'd2
    } fetch_state_t;

    // addi x0, x0, 0 -- the architectural bubble.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // IF/ID pipeline record, also consumed by the decode stage.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
    } if_id_t;

    // True when the word index of a byte address falls outside the memory.
    function automatic logic pc_out_of_range(input logic [31:0] pc, input logic [29:0] limit);
        return (pc[31:2] >= limit);
    endfunction

    // True when a byte address is not word aligned.
    function automatic logic pc_misaligned(input logic [31:0] pc);
        return (pc[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures pc, pc+4 and instruction for decode.
// Latency: one cycle from load inputs to outputs.
// Backpressure: hold freezes all fields; flush (higher priority) inserts a bubble keeping pc/pc4.
module if_id_reg
    import rv_pipe_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = rv_pipe_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        hold,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_pc4,
    input  logic [31:0] load_instr,
    output if_id_t      q
);

    // Flush beats hold; pc/pc4 are left alone on a flush so decode still sees the last address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.valid <= 1'b0;
            q.pc    <= 32'h0;
            q.pc4   <= 32'h0;
            q.instr <= NOP_INSTR;
        end else if (flush) begin
            q.valid <= 1'b0;
            q.instr <= NOP_INSTR;
        end else if (!hold) begin
            q.valid <= 1'b1;
            q.pc    <= load_pc;
            q.pc4   <= load_pc4;
            q.instr <= load_instr;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the PC, addresses imem combinationally and fills IF/ID.
// Latency: one cycle PC -> IF/ID; a redirect costs exactly one bubble.
// Backpressure: stall holds PC and IF/ID; redirect overrides stall; a fault halts until reset.
module if_fetch_stage
    import rv_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR  = rv_pipe_pkg::NOP_INSTR,
    parameter int unsigned IMEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_instr_i,
    output logic        if_id_valid_o,
    output logic [31:0] if_id_pc_o,
    output logic [31:0] if_id_pc4_o,
    output logic [31:0] if_id_instr_o,
    output logic [31:0] fetch_count_o,
    output logic        fault_o,
    output logic [31:0] fault_pc_o
);

    localparam logic [29:0] IMEM_LIMIT = 30'(IMEM_WORDS);

    fetch_state_t state;
    logic [31:0]  pc_q;
    logic [31:0]  pc_plus4;
    logic [31:0]  fetch_count;
    logic         fault;
    logic [31:0]  fault_pc;

    logic         redirect_bad;
    logic         pc_bad;
    logic         ifid_flush;
    logic         ifid_hold;
    if_id_t       ifid_q;

    assign pc_plus4 = pc_q + 32'd4;

    // Classify the current PC and any redirect target before the FSM acts on them.
    always_comb begin
        redirect_bad = pc_misaligned(redirect_pc_i) || pc_out_of_range(redirect_pc_i, IMEM_LIMIT);
        pc_bad       = pc_out_of_range(pc_q, IMEM_LIMIT);
    end

    // IF/ID controls: only RUN ever changes the register; any redirect or fault flushes it.
    always_comb begin
        ifid_flush = 1'b0;
        ifid_hold  = 1'b1;
        if (state == FETCH_RUN) begin
            ifid_flush = redirect_valid_i || pc_bad;
            ifid_hold  = !(redirect_valid_i || pc_bad) && stall_i;
        end
    end

    // Fetch FSM with PC, fetch counter and sticky fault capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH_BOOT;
            pc_q        <= RESET_PC;
            fetch_count <= 32'h0;
            fault       <= 1'b0;
            fault_pc    <= 32'h0;
        end else begin
            case (state)
                FETCH_BOOT: begin
                    state <= FETCH_RUN;
                end
                FETCH_RUN: begin
                    if (redirect_valid_i) begin
                        if (redirect_bad) begin
                            state    <= FETCH_HALT;
                            fault    <= 1'b1;
                            fault_pc <= redirect_pc_i;
                        end else begin
                            pc_q <= redirect_pc_i;
                        end
                    end else if (pc_bad) begin
                        state    <= FETCH_HALT;
                        fault    <= 1'b1;
                        fault_pc <= pc_q;
                    end else if (!stall_i) begin
                        pc_q        <= pc_plus4;
                        fetch_count <= fetch_count + 32'd1;
                    end
                end
                FETCH_HALT: begin
                    // Frozen until reset.
                end
                default: begin
                    state <= FETCH_HALT;
                end
            endcase
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (ifid_flush),
        .hold       (ifid_hold),
        .load_pc    (pc_q),
        .load_pc4   (pc_plus4),
        .load_instr (imem_instr_i),
        .q          (ifid_q)
    );

    assign imem_addr_o   = pc_q;
    assign if_id_valid_o = ifid_q.valid;
    assign if_id_pc_o    = ifid_q.pc;
    assign if_id_pc4_o   = ifid_q.pc4;
    assign if_id_instr_o = ifid_q.instr;
    assign fetch_count_o = fetch_count;
    assign fault_o       = fault;
    assign fault_pc_o    = fault_pc;

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage RISC-V pipeline. Owns the program counter and drives the word address into the instruction memory.
- The instruction memory reads combinationally: the instruction for `imem_addr_o` is valid in the same cycle.
- Captures the PC, PC+4 and the instruction into the IF/ID pipeline register for decode.
- Handles hazard-unit stalls, EX-stage branch/jump redirects and fetch faults (misaligned or out-of-range PC).

Parameters:
- RESET_PC, 32'h0000_0000, PC value fetched on the first cycle after reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) loaded into IF/ID on flush or invalid.
- IMEM_WORDS, 1024, instruction memory depth in 32-bit words; PC word index must be below this.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall_i  in  1  hazard unit: hold PC and IF/ID.
- redirect_valid_i  in  1  EX stage: taken branch or jump this cycle.
- redirect_pc_i  in  32  redirect target.
- imem_addr_o  out  32  byte address to instruction memory (equals pc_q).
- imem_instr_i  in  32  instruction returned combinationally for imem_addr_o.
- if_id_valid_o  out  1  IF/ID holds a real instruction.
- if_id_pc_o  out  32  PC of the IF/ID instruction.
- if_id_pc4_o  out  32  PC+4 of the IF/ID instruction.
- if_id_instr_o  out  32  instruction, or NOP_INSTR when invalid.
- fetch_count_o  out  32  number of valid IF/ID loads, wraps modulo 2^32.
- fault_o  out  1  sticky fetch fault.
- fault_pc_o  out  32  offending PC or target.

Behaviour:
- Reset (async assert, rst_n=0):
  - state=BOOT, pc_q=RESET_PC, if_id_valid_o=0, if_id_pc_o=0, if_id_pc4_o=0, if_id_instr_o=NOP_INSTR.
  - fetch_count_o=0, fault_o=0, fault_pc_o=0.
  - Reset asserted mid-operation discards all state immediately.
- FSM states: BOOT, RUN, HALT.
  - BOOT: exactly one cycle after rst_n rises. Loads nothing into IF/ID. Next state is RUN. stall_i and redirect_valid_i are ignored.
  - RUN, per rising edge, checked in this priority order:
    1. redirect_valid_i=1:
       - If redirect_pc_i[1:0]!=0 or redirect_pc_i[31:2]>=IMEM_WORDS: go to HALT, fault_o=1, fault_pc_o=redirect_pc_i.
       - Otherwise pc_q=redirect_pc_i.
       - In both cases IF/ID is flushed: valid=0, instr=NOP_INSTR, pc/pc4 unchanged.
       - Redirect overrides a simultaneous stall.
    2. Otherwise, if pc_q[31:2]>=IMEM_WORDS: go to HALT, fault_o=1, fault_pc_o=pc_q, IF/ID is flushed.
    3. Otherwise, if stall_i=1: pc_q and all IF/ID fields hold; fetch_count_o holds.
    4. Otherwise: IF/ID = {valid=1, pc_q, pc_q+4, imem_instr_i}; pc_q=pc_q+4; fetch_count_o increments.
  - HALT: pc_q, IF/ID (invalid, NOP) and fault outputs are frozen. All inputs are ignored. Exit is by reset only.
- Arithmetic:
  - PC+4 is 32-bit modulo. 32'hFFFF_FFFC wraps to 0, but it is caught as out-of-range first for any IMEM_WORDS<2^30.
  - The instruction memory uses only imem_addr_o[11:2] (for IMEM_WORDS=1024).
  - pc_q[1:0] is always 2'b00.
- Latency:
  - One cycle from PC to IF/ID.
  - A redirect asserted in cycle N puts the target's instruction valid in IF/ID after edge N+2, giving exactly one bubble.
- All outputs are registered except imem_addr_o, which is a direct copy of pc_q.

Decomposition:
- Shared package `rv_pipe_pkg`:
  - fetch state enum (BOOT, RUN, HALT).
  - NOP_INSTR constant.
  - IF/ID struct typedef {valid, pc, pc4, instr}, reused by the decode stage.
- Natural sub-module: `if_id_reg`, the IF/ID pipeline register with hold and flush controls.
- PC, FSM and fault logic stay in if_fetch_stage.

Test Plan:
- Reset release, memory words 0..3 = 0x00100093, 0x00200113, 0x00300193, 0x00400213:
  - Cycle 1 after release (BOOT): valid=0.
  - Then IF/ID shows pc=0 with 0x00100093, pc=4 with 0x00200113, and so on.
  - fetch_count_o=4 after four RUN edges.
- stall_i high for 3 cycles while pc_q=8: imem_addr_o stays 8, IF/ID holds pc=4, fetch_count_o does not change. Fetch resumes with pc=8.
- redirect_valid_i=1 with target 0x40 and stall_i=1 in the same cycle: next edge gives valid=0, instr=0x00000013, pc_q=0x40. The following edge loads pc=0x40 and mem[16].
- Redirect to 0x42 (misaligned): fault_o=1, fault_pc_o=0x42, FSM in HALT, outputs frozen for 10 cycles despite input toggles.
- Sequential run to pc=0xFFC then +4: at pc_q=0x1000 the next edge gives fault_o=1, fault_pc_o=0x1000, valid=0.
- rst_n pulsed low mid-stream with fault set: fault_o, valid and fetch_count_o clear asynchronously, pc_q=RESET_PC, and the BOOT, RUN sequence repeats.
